// File: rtl/life_gen_engine.sv
// Sequential Game-of-Life generation engine with a double-buffered board.
// The display bank feeds the renderer while the next generation is built in the back bank.

// Protocol checks on the engine outputs, bound from the engine itself.
module life_gen_checker (
    input logic       clk,
    input logic       reset,
    input logic       busy,
    input logic       gen_done,
    input logic [7:0] gen_count
);

    a_done_single_cycle: assert property (@(posedge clk) disable iff (reset)
        gen_done |=> !gen_done);

    a_done_when_idle: assert property (@(posedge clk) disable iff (reset)
        gen_done |-> !busy);

    a_count_steps_with_done: assert property (@(posedge clk) disable iff (reset)
        gen_done |-> (gen_count == ($past(gen_count) + 8'd1)));

endmodule

module life_gen_engine #(
    parameter int BIT_WIDTH      = 3,
    parameter int BIT_HEIGHT     = 3,
    parameter int FRAMES_PER_GEN = 60,
    parameter logic [(2**(BIT_WIDTH+BIT_HEIGHT))-1:0] SEED = 64'h0000_0000_0007_0402
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_tick,
    input  logic                            run,
    input  logic                            load,
    input  logic [BIT_WIDTH+BIT_HEIGHT-1:0] rd_addr,
    output logic                            rd_data,
    output logic                            busy,
    output logic                            gen_done,
    output logic [7:0]                      gen_count,
    output logic                            extinct
);

    localparam int B    = BIT_WIDTH + BIT_HEIGHT;
    localparam int W    = 2 ** BIT_WIDTH;
    localparam int SIZE = 2 ** B;
    localparam int FCW  = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    localparam logic [B-1:0]   STEP_ROW   = B'(W);
    localparam logic [B-1:0]   STEP_ONE   = B'(1);
    localparam logic [B-1:0]   LAST_IDX   = B'(SIZE - 1);
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SIZE-1:0]  bank0_r;
    logic [SIZE-1:0]  bank1_r;
    logic             sel_r;
    logic [B-1:0]     idx_r;
    logic [FCW-1:0]   frame_cnt_r;
    logic [7:0]       gen_count_r;
    logic             gen_done_r;
    logic             extinct_r;
    logic             any_live_r;

    logic [SIZE-1:0]  display_s;
    logic [3:0]       n_s;
    logic             next_bit_s;
    logic             tick_ok_s;
    logic             last_frame_s;
    logic             busy_s;

    // Live neighbours of one cell; board edges do not wrap, so masked-off taps read as dead.
    function automatic logic [3:0] count_neighbours(input logic [SIZE-1:0] board,
                                                    input logic [B-1:0]    idx);
        logic [BIT_HEIGHT-1:0] row;
        logic [BIT_WIDTH-1:0]  col;
        logic                  up;
        logic                  dn;
        logic                  lf;
        logic                  rt;
        logic [3:0]            n;
        row = idx[B-1:BIT_WIDTH];
        col = idx[BIT_WIDTH-1:0];
        up  = (row != {BIT_HEIGHT{1'b0}});
        dn  = (row != {BIT_HEIGHT{1'b1}});
        lf  = (col != {BIT_WIDTH{1'b0}});
        rt  = (col != {BIT_WIDTH{1'b1}});
        n   = 4'd0;
        n   = n + {3'b000, up & lf & board[idx - STEP_ROW - STEP_ONE]};
        n   = n + {3'b000, up      & board[idx - STEP_ROW]};
        n   = n + {3'b000, up & rt & board[idx - STEP_ROW + STEP_ONE]};
        n   = n + {3'b000, lf      & board[idx - STEP_ONE]};
        n   = n + {3'b000, rt      & board[idx + STEP_ONE]};
        n   = n + {3'b000, dn & lf & board[idx + STEP_ROW - STEP_ONE]};
        n   = n + {3'b000, dn      & board[idx + STEP_ROW]};
        n   = n + {3'b000, dn & rt & board[idx + STEP_ROW + STEP_ONE]};
        return n;
    endfunction

    // Display bank selection, neighbour count and the next-state rule for the cell at idx.
    always_comb begin
        display_s    = sel_r ? bank1_r : bank0_r;
        n_s          = count_neighbours(display_s, idx_r);
        tick_ok_s    = frame_tick && run;
        last_frame_s = (frame_cnt_r == LAST_FRAME);
        if (display_s[idx_r]) begin
            next_bit_s = (n_s == 4'd2) || (n_s == 4'd3);
        end else begin
            next_bit_s = (n_s == 4'd3);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; load aborts any generation in flight.
    always_comb begin
        state_nxt_s = state_r;
        if (load) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_ok_s && last_frame_s) begin
                        state_nxt_s = ST_COMPUTE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_COMPUTE: begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_SWAP;
                    end else begin
                        state_nxt_s = ST_COMPUTE;
                    end
                end
                ST_SWAP:  state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        case (state_r)
            ST_COMPUTE: busy_s = 1'b1;
            ST_SWAP:    busy_s = 1'b1;
            ST_IDLE:    busy_s = 1'b0;
            default:    busy_s = 1'b0;
        endcase
    end

    // Board banks, frame pacing, cell index and generation status.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank0_r     <= SEED;
            bank1_r     <= {SIZE{1'b0}};
            sel_r       <= 1'b0;
            idx_r       <= {B{1'b0}};
            frame_cnt_r <= {FCW{1'b0}};
            gen_count_r <= 8'd0;
            gen_done_r  <= 1'b0;
            extinct_r   <= (SEED == {SIZE{1'b0}});
            any_live_r  <= 1'b0;
        end else if (load) begin
            if (sel_r) begin
                bank1_r <= SEED;
            end else begin
                bank0_r <= SEED;
            end
            idx_r       <= {B{1'b0}};
            frame_cnt_r <= {FCW{1'b0}};
            gen_count_r <= 8'd0;
            gen_done_r  <= 1'b0;
            extinct_r   <= (SEED == {SIZE{1'b0}});
            any_live_r  <= 1'b0;
        end else begin
            gen_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tick_ok_s && last_frame_s) begin
                        frame_cnt_r <= {FCW{1'b0}};
                        idx_r       <= {B{1'b0}};
                    end else if (tick_ok_s) begin
                        frame_cnt_r <= frame_cnt_r + FCW'(1);
                    end else begin
                        frame_cnt_r <= frame_cnt_r;
                    end
                end
                ST_COMPUTE: begin
                    // Only the back bank is written, so rd_data never sees a half-built board.
                    if (sel_r) begin
                        bank0_r[idx_r] <= next_bit_s;
                    end else begin
                        bank1_r[idx_r] <= next_bit_s;
                    end
                    any_live_r <= (idx_r == {B{1'b0}}) ? next_bit_s : (any_live_r | next_bit_s);
                    idx_r      <= idx_r + STEP_ONE;
                end
                ST_SWAP: begin
                    sel_r       <= ~sel_r;
                    gen_count_r <= gen_count_r + 8'd1;
                    gen_done_r  <= 1'b1;
                    extinct_r   <= ~any_live_r;
                end
                default: begin
                    gen_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = display_s[rd_addr];
    assign busy      = busy_s;
    assign gen_done  = gen_done_r;
    assign gen_count = gen_count_r;
    assign extinct   = extinct_r;

    life_gen_checker u_checker (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy_s),
        .gen_done  (gen_done_r),
        .gen_count (gen_count_r)
    );

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench for life_gen_engine: four instances with different seeds and pacing,
// expected boards worked out by hand for glider, blinker, block and a lone cell.
`timescale 1ns/1ps
module tb_life_gen_engine;

    localparam int N = 4;
    localparam logic [63:0] GLIDER    = 64'h0000_0000_0007_0402;
    localparam logic [63:0] BLINK_H   = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V   = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK     = 64'h0000_0000_0000_0303;
    localparam logic [63:0] LONE      = 64'h8000_0000_0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   frame_tick;
    logic [N-1:0]   run;
    logic [N-1:0]   load;
    logic [N-1:0]   rd_data;
    logic [N-1:0]   busy;
    logic [N-1:0]   gen_done;
    logic [N-1:0]   extinct;
    logic [5:0]     rd_addr   [N];
    logic [7:0]     gen_count [N];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    life_gen_engine #(.FRAMES_PER_GEN(60), .SEED(GLIDER)) u_glider (
        .clk(clk), .reset(reset), .frame_tick(frame_tick[0]), .run(run[0]), .load(load[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .busy(busy[0]), .gen_done(gen_done[0]),
        .gen_count(gen_count[0]), .extinct(extinct[0]));

    life_gen_engine #(.FRAMES_PER_GEN(1), .SEED(BLINK_H)) u_blink (
        .clk(clk), .reset(reset), .frame_tick(frame_tick[1]), .run(run[1]), .load(load[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .busy(busy[1]), .gen_done(gen_done[1]),
        .gen_count(gen_count[1]), .extinct(extinct[1]));

    life_gen_engine #(.FRAMES_PER_GEN(1), .SEED(BLOCK)) u_block (
        .clk(clk), .reset(reset), .frame_tick(frame_tick[2]), .run(run[2]), .load(load[2]),
        .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .busy(busy[2]), .gen_done(gen_done[2]),
        .gen_count(gen_count[2]), .extinct(extinct[2]));

    life_gen_engine #(.FRAMES_PER_GEN(1), .SEED(LONE)) u_lone (
        .clk(clk), .reset(reset), .frame_tick(frame_tick[3]), .run(run[3]), .load(load[3]),
        .rd_addr(rd_addr[3]), .rd_data(rd_data[3]), .busy(busy[3]), .gen_done(gen_done[3]),
        .gen_count(gen_count[3]), .extinct(extinct[3]));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick(input int d);
        frame_tick[d] = 1'b1;
        @(posedge clk);
        #1;
        frame_tick[d] = 1'b0;
    endtask

    // Sweeps rd_addr one address per clock, sampling on the falling edge.
    task automatic read_board(input int d, output logic [63:0] b);
        for (int a = 0; a < 64; a++) begin
            rd_addr[d] = 6'(a);
            @(negedge clk);
            b[a] = rd_data[d];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gen(input int d);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = gen_done[d];
        end
        check_val("gen_done_seen", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] board;
        logic        flag;
        reset      = 1'b1;
        frame_tick = '0;
        run        = '0;
        load       = '0;
        for (int i = 0; i < N; i++) rd_addr[i] = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state with the default glider seed
        check_val("rst_busy",      {63'd0, busy[0]},     64'd0);
        check_val("rst_gen_done",  {63'd0, gen_done[0]}, 64'd0);
        check_val("rst_gen_count", {56'd0, gen_count[0]}, 64'd0);
        check_val("rst_extinct",   {63'd0, extinct[0]},  64'd0);
        read_board(0, board);
        check_val("rst_board", board, GLIDER);

        // Pacing: 59 ticks do nothing, the 60th starts a generation
        run[0] = 1'b1;
        flag   = 1'b0;
        for (int i = 0; i < 59; i++) begin
            pulse_tick(0);
            flag = flag | busy[0];
            idle(1);
            flag = flag | busy[0];
        end
        check_val("busy_59_ticks", {63'd0, flag}, 64'd0);
        pulse_tick(0);
        check_val("busy_60th_tick", {63'd0, busy[0]}, 64'd1);
        for (int i = 0; i < 30; i++) pulse_tick(0);
        wait_gen(0);
        check_val("glider_gen1_count", {56'd0, gen_count[0]}, 64'd1);

        // run=0 freezes the frame counter
        run[0] = 1'b0;
        flag   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            pulse_tick(0);
            flag = flag | busy[0];
            idle(1);
        end
        check_val("busy_run0", {63'd0, flag}, 64'd0);
        check_val("count_run0", {56'd0, gen_count[0]}, 64'd1);
        run[0] = 1'b1;
        flag   = 1'b0;
        for (int i = 0; i < 59; i++) begin
            pulse_tick(0);
            flag = flag | busy[0];
            idle(1);
            flag = flag | busy[0];
        end
        check_val("busy_after_freeze", {63'd0, flag}, 64'd0);
        pulse_tick(0);
        check_val("busy_second_gen", {63'd0, busy[0]}, 64'd1);

        // Load at idx 30 of COMPUTE discards the generation
        idle(30);
        load[0] = 1'b1;
        @(posedge clk);
        #1;
        load[0] = 1'b0;
        check_val("load_busy",      {63'd0, busy[0]},      64'd0);
        check_val("load_gen_count", {56'd0, gen_count[0]}, 64'd0);
        check_val("load_extinct",   {63'd0, extinct[0]},   64'd0);
        flag = gen_done[0];
        for (int i = 0; i < 80; i++) begin
            idle(1);
            flag = flag | gen_done[0];
        end
        check_val("load_no_done", {63'd0, flag}, 64'd0);
        read_board(0, board);
        check_val("load_board", board, GLIDER);

        // Blinker with one tick per generation: exact latency
        run[1] = 1'b1;
        read_board(1, board);
        check_val("blink_rst_board", board, BLINK_H);
        pulse_tick(1);
        check_val("blink_busy", {63'd0, busy[1]}, 64'd1);
        idle(64);
        check_val("blink_done_early", {63'd0, gen_done[1]}, 64'd0);
        check_val("blink_busy_swap",  {63'd0, busy[1]},     64'd1);
        idle(1);
        check_val("blink_done_e65", {63'd0, gen_done[1]}, 64'd1);
        check_val("blink_idle_e65", {63'd0, busy[1]},     64'd0);
        idle(1);
        check_val("blink_done_drop", {63'd0, gen_done[1]}, 64'd0);
        read_board(1, board);
        check_val("blink_gen1_board", board, BLINK_V);
        check_val("blink_gen1_count", {56'd0, gen_count[1]}, 64'd1);

        // Sweep the display bank while the second generation computes
        pulse_tick(1);
        read_board(1, board);
        check_val("sweep_during_compute", board, BLINK_V);
        wait_gen(1);
        read_board(1, board);
        check_val("blink_gen2_board", board, BLINK_H);
        check_val("blink_gen2_count", {56'd0, gen_count[1]}, 64'd2);

        // gen_count wraps on the 256th generation
        for (int g = 3; g <= 256; g++) begin
            pulse_tick(1);
            wait_gen(1);
            if (g == 255) check_val("count_255", {56'd0, gen_count[1]}, 64'd255);
        end
        check_val("count_wrap", {56'd0, gen_count[1]}, 64'd0);
        read_board(1, board);
        check_val("blink_gen256_board", board, BLINK_H);

        // Block in the corner is stable with no wrap-around
        run[2] = 1'b1;
        for (int g = 0; g < 3; g++) begin
            pulse_tick(2);
            wait_gen(2);
        end
        read_board(2, board);
        check_val("block_board",   board, BLOCK);
        check_val("block_count",   {56'd0, gen_count[2]}, 64'd3);
        check_val("block_extinct", {63'd0, extinct[2]},   64'd0);

        // Lone corner cell dies
        run[3] = 1'b1;
        check_val("lone_extinct_pre", {63'd0, extinct[3]}, 64'd0);
        pulse_tick(3);
        wait_gen(3);
        check_val("lone_extinct", {63'd0, extinct[3]}, 64'd1);
        check_val("lone_count",   {56'd0, gen_count[3]}, 64'd1);
        read_board(3, board);
        check_val("lone_board", board, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
